// File: rtl/rv32_mc_controller.sv
// Multicycle RV32I(+M) control unit: Moore FSM that sequences fetch, decode,
// execute, memory and writeback for a shared-ALU, single-memory datapath.
// Handles variable-latency memory, optional iterative mul/div dispatch and
// halts on illegal instructions.
module rv32_mc_controller #(
  parameter bit MEM_WAIT  = 1'b1,
  parameter bit MULDIV_EN = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       eq,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  input  logic       mul_done,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic [2:0] LdStrSrc,
  output logic       mul_start,
  output logic       retire,
  output logic       trap
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UTYPE    = 4'd12,
    S_MULDIV   = 4'd13,
    S_MULWB    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  state_t state_q, state_d;
  logic   mul_busy_q, mul_busy_d;
  logic   ready_s;

  // ALU operation for register (is_r=1) or immediate arithmetic.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7_5,
                                            input logic is_r);
    logic [3:0] ctl;
    case (f3)
      3'b000:  ctl = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  ctl = ALU_SLL;
      3'b010:  ctl = ALU_SLT;
      3'b011:  ctl = ALU_SLTU;
      3'b100:  ctl = ALU_XOR;
      3'b101:  ctl = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  ctl = ALU_OR;
      3'b111:  ctl = ALU_AND;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // Branch condition from the ALU compare flags.
  function automatic logic branch_taken(input logic [2:0] f3, input logic f_eq,
                                        input logic f_lt, input logic f_ltu);
    logic tk;
    case (f3)
      3'b000:  tk = f_eq;
      3'b001:  tk = !f_eq;
      3'b100:  tk = f_lt;
      3'b101:  tk = !f_lt;
      3'b110:  tk = f_ltu;
      3'b111:  tk = !f_ltu;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  // Without a waiting memory every access completes in its first cycle.
  assign ready_s = MEM_WAIT ? mem_ready : 1'b1;

  // State register and mul/div entry flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      mul_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mul_busy_q <= mul_busy_d;
    end
  end

  // Next-state and Moore outputs; everything forced low while reset is held.
  always_comb begin
    state_d    = state_q;
    mul_busy_d = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ResultSrc  = 2'b00;
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
    LdStrSrc   = 3'b000;
    mul_start  = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;
    if (reset_n) begin
      LdStrSrc = funct3;
      case (state_q)
        S_FETCH: begin
          MemRead   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = 2'b10;
          IRWrite   = ready_s;
          PCWrite   = ready_s;
          state_d   = ready_s ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
          case (op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE: begin
              if (funct7 == F7_MULDIV) begin
                state_d = MULDIV_EN ? S_MULDIV : S_TRAP;
              end else begin
                state_d = S_EXECUTER;
              end
            end
            OP_ITYPE:  state_d = S_EXECUTEI;
            OP_BRANCH: state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
            OP_JAL:    state_d = S_JAL;
            OP_JALR:   state_d = S_JALR;
            OP_LUI, OP_AUIPC: state_d = S_UTYPE;
            default:   state_d = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = (op == OP_LOAD) ? IMM_I : IMM_S;
          state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          AdrSrc  = 1'b1;
          MemRead = 1'b1;
          state_d = ready_s ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          retire   = ready_s;
          state_d  = ready_s ? S_FETCH : S_MEMWRITE;
        end
        S_EXECUTER: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_RS2;
          ALUControl = alu_decode(funct3, funct7[5], 1'b1);
          state_d    = S_ALUWB;
        end
        S_EXECUTEI: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_IMM;
          ImmSrc     = IMM_I;
          ALUControl = alu_decode(funct3, funct7[5], 1'b0);
          state_d    = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_RS2;
          ALUControl = ALU_SUB;
          PCWrite    = branch_taken(funct3, eq, lt, ltu);
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_JALR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_I;
          state_d = S_JAL;
        end
        S_JAL: begin
          // ALUOut holds the target; the ALU forms the link value PC+4.
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
          state_d = S_ALUWB;
        end
        S_UTYPE: begin
          ALUSrcA = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_U;
          state_d = S_ALUWB;
        end
        S_MULDIV: begin
          mul_start = !mul_busy_q;
          if (mul_done) begin
            state_d = S_MULWB;
          end else begin
            state_d    = S_MULDIV;
            mul_busy_d = 1'b1;
          end
        end
        S_MULWB: begin
          ResultSrc = 2'b11;
          RegWrite  = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_TRAP: begin
          trap    = 1'b1;
          state_d = S_TRAP;
        end
        default: begin
          state_d = S_TRAP;
        end
      endcase
    end else begin
      state_d = S_FETCH;
    end
  end

endmodule

// File: tb/tb_rv32_mc_controller.sv
// Self-checking bench for rv32_mc_controller: directed scenarios plus a
// randomized instruction stream compared against a per-instruction model of
// latency and strobe counts.
module tb_rv32_mc_controller;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_M      = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       eq = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic       mem_ready = 1'b0, mul_done = 1'b0;

  logic PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc, mul_start, retire, trap;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc, LdStrSrc;
  logic [3:0] ALUControl;
  logic n_PCWrite, n_IRWrite, n_RegWrite, n_MemWrite, n_MemRead, n_AdrSrc;
  logic n_mul_start, n_retire, n_trap;
  logic [1:0] n_ALUSrcA, n_ALUSrcB, n_ResultSrc;
  logic [2:0] n_ImmSrc, n_LdStrSrc;
  logic [3:0] n_ALUControl;
  logic [24:0] outs1, outs0;

  assign outs1 = {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc, ALUSrcA, ALUSrcB,
                  ResultSrc, ImmSrc, ALUControl, LdStrSrc, mul_start, retire, trap};
  assign outs0 = {n_PCWrite, n_IRWrite, n_RegWrite, n_MemWrite, n_MemRead, n_AdrSrc,
                  n_ALUSrcA, n_ALUSrcB, n_ResultSrc, n_ImmSrc, n_ALUControl, n_LdStrSrc,
                  n_mul_start, n_retire, n_trap};

  rv32_mc_controller #(.MEM_WAIT(1'b1), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7(funct7),
    .eq(eq), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mul_done(mul_done),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemRead(MemRead), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .LdStrSrc(LdStrSrc),
    .mul_start(mul_start), .retire(retire), .trap(trap)
  );

  rv32_mc_controller #(.MEM_WAIT(1'b1), .MULDIV_EN(1'b0)) dut_nomul (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7(funct7),
    .eq(eq), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mul_done(mul_done),
    .PCWrite(n_PCWrite), .IRWrite(n_IRWrite), .RegWrite(n_RegWrite), .MemWrite(n_MemWrite),
    .MemRead(n_MemRead), .AdrSrc(n_AdrSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
    .ResultSrc(n_ResultSrc), .ImmSrc(n_ImmSrc), .ALUControl(n_ALUControl),
    .LdStrSrc(n_LdStrSrc), .mul_start(n_mul_start), .retire(n_retire), .trap(n_trap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent instruction.
  int c_cyc, c_ret, c_rw, c_mw, c_mr, c_ir, c_irbad, c_pc, c_ms, c_adr;
  logic       last_pc;
  logic [1:0] rs_rw;
  logic [2:0] ld_src;
  logic [3:0] alu_at [0:63];

  // Behavioural model: cycles from first FETCH cycle to the retiring cycle.
  function automatic int model_cycles(input logic [6:0] o, input logic [6:0] f7,
                                      input int fw, input int mw, input int mk);
    int n;
    case (o)
      OP_LOAD:  n = 5 + mw;
      OP_STORE: n = 4 + mw;
      OP_R:     n = (f7 == F7_M) ? 4 + mk : 4;
      OP_BR:    n = 3;
      OP_JALR:  n = 5;
      default:  n = 4;
    endcase
    return n + fw;
  endfunction

  function automatic logic [3:0] model_alu(input logic is_r, input logic [2:0] f3,
                                           input logic [6:0] f7);
    logic [3:0] r;
    case (f3)
      3'd0:    r = (is_r && f7[5]) ? 4'd1 : 4'd0;
      3'd1:    r = 4'd2;
      3'd2:    r = 4'd3;
      3'd3:    r = 4'd4;
      3'd4:    r = 4'd5;
      3'd5:    r = f7[5] ? 4'd7 : 4'd6;
      3'd6:    r = 4'd8;
      default: r = 4'd9;
    endcase
    return r;
  endfunction

  function automatic logic model_taken(input logic [2:0] f3, input logic e,
                                       input logic l, input logic lu);
    logic t;
    case (f3)
      3'd0:    t = e;
      3'd1:    t = !e;
      3'd4:    t = l;
      3'd5:    t = !l;
      3'd6:    t = lu;
      default: t = !lu;
    endcase
    return t;
  endfunction

  // Drive one instruction from FETCH until retire or trap; called at a falling edge.
  task automatic run_instr(input logic [6:0] iop, input logic [2:0] if3, input logic [6:0] if7,
                           input int fw, input int mw, input int mk);
    int fl, ml, mcnt;
    logic in_mul, done;
    op = iop; funct3 = if3; funct7 = if7;
    fl = fw; ml = mw; mcnt = 0; in_mul = 1'b0; done = 1'b0;
    c_cyc = 0; c_ret = 0; c_rw = 0; c_mw = 0; c_mr = 0; c_ir = 0; c_irbad = 0;
    c_pc = 0; c_ms = 0; c_adr = 0; last_pc = 1'b0; rs_rw = 2'b00; ld_src = 3'b000;
    while (!done) begin
      #1;
      if (MemRead || MemWrite) begin
        if (AdrSrc) begin mem_ready = (ml == 0); if (ml > 0) ml--; end
        else begin mem_ready = (fl == 0); if (fl > 0) fl--; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (mul_start) in_mul = 1'b1;
      mul_done = in_mul ? (mcnt >= mk) : 1'($urandom_range(0, 1));
      if (in_mul) mcnt++;
      #1;
      if (c_cyc < 64) alu_at[c_cyc] = ALUControl;
      if (retire) begin c_ret++; last_pc = PCWrite; end
      if (RegWrite) begin c_rw++; rs_rw = ResultSrc; end
      if (MemWrite) c_mw++;
      if (MemRead) c_mr++;
      if (MemRead && AdrSrc) ld_src = LdStrSrc;
      if (AdrSrc) c_adr++;
      if (IRWrite) c_ir++;
      if (IRWrite && !mem_ready) c_irbad++;
      if (PCWrite) c_pc++;
      if (mul_start) c_ms++;
      c_cyc++;
      if (retire || trap) begin
        done = 1'b1;
      end else if (c_cyc >= 60) begin
        checks++; errors++;
        $display("FAIL timeout op=%b: no retire within %0d cycles", iop, c_cyc);
        done = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; mem_ready = 1'b0; mul_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (outs1 !== 25'd0) begin errors++; $display("FAIL reset_outs got %h want 0", outs1); end
    checks++; if (outs0 !== 25'd0) begin errors++; $display("FAIL reset_outs_nomul got %h want 0", outs0); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if ({MemRead, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, IRWrite} !== 9'b1_0_00_10_10_0) begin
      errors++; $display("FAIL first_fetch got %b want 100010100", {MemRead, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, IRWrite});
    end
    @(negedge clk);
    #1;
    checks++; if ({MemRead, IRWrite, PCWrite} !== 3'b100) begin
      errors++; $display("FAIL fetch_hold got %b want 100", {MemRead, IRWrite, PCWrite});
    end
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    for (int i = 0; i < 2; i++) begin
      run_instr(OP_R, 3'b000, (i == 1) ? 7'b0100000 : 7'b0000000, 0, 0, 0);
      checks++; if (c_cyc !== 4) begin errors++; $display("FAIL addsub_cycles i=%0d got %0d want 4", i, c_cyc); end
      checks++; if (alu_at[2] !== ((i == 1) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL addsub_aluctl i=%0d got %b want %0d", i, alu_at[2], i);
      end
      checks++; if (c_ret !== 1 || c_rw !== 1) begin
        errors++; $display("FAIL addsub_retire i=%0d got ret=%0d rw=%0d want 1 1", i, c_ret, c_rw);
      end
    end
  endtask

  task automatic test_load_wait();
    run_instr(OP_LOAD, 3'b101, 7'd0, 0, 3, 0);
    checks++; if (c_cyc !== 8) begin errors++; $display("FAIL load_cycles got %0d want 8", c_cyc); end
    checks++; if (c_mr !== 5 || c_adr !== 4) begin
      errors++; $display("FAIL load_memread got mr=%0d adr=%0d want 5 4", c_mr, c_adr);
    end
    checks++; if (c_rw !== 1 || rs_rw !== 2'b01) begin
      errors++; $display("FAIL load_wb got rw=%0d rs=%b want 1 01", c_rw, rs_rw);
    end
    checks++; if (ld_src !== 3'b101) begin errors++; $display("FAIL load_ldstrsrc got %b want 101", ld_src); end
  endtask

  task automatic test_bne();
    for (int i = 0; i < 2; i++) begin
      eq = (i == 0);
      run_instr(OP_BR, 3'b001, 7'd0, 0, 0, 0);
      checks++; if (c_cyc !== 3) begin errors++; $display("FAIL bne_cycles eq=%0b got %0d want 3", eq, c_cyc); end
      checks++; if (last_pc !== !eq) begin errors++; $display("FAIL bne_pcwrite eq=%0b got %0b want %0b", eq, last_pc, !eq); end
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    run_instr(OP_R, 3'b000, F7_M, 0, 0, 5);
    checks++; if (c_cyc !== 9) begin errors++; $display("FAIL mul_cycles got %0d want 9", c_cyc); end
    checks++; if (c_ms !== 1) begin errors++; $display("FAIL mul_start_pulses got %0d want 1", c_ms); end
    checks++; if (c_rw !== 1 || rs_rw !== 2'b11) begin
      errors++; $display("FAIL mul_wb got rw=%0d rs=%b want 1 11", c_rw, rs_rw);
    end
    repeat (3) begin
      #1;
      checks++; if (n_trap !== 1'b1 || n_RegWrite !== 1'b0) begin
        errors++; $display("FAIL nomul_trap got trap=%0b rw=%0b want 1 0", n_trap, n_RegWrite);
      end
      @(negedge clk);
    end
    run_instr(OP_R, 3'b100, F7_M, 1, 0, 0);
    checks++; if (c_cyc !== 5 || c_ms !== 1) begin
      errors++; $display("FAIL mul_done_early got cyc=%0d starts=%0d want 5 1", c_cyc, c_ms);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(OP_BR, 3'b010, 7'd0, 0, 0, 0);
    checks++; if (trap !== 1'b1 || c_cyc !== 3 || c_ret !== 0) begin
      errors++; $display("FAIL branch010_trap got trap=%0b cyc=%0d ret=%0d want 1 3 0", trap, c_cyc, c_ret);
    end
    do_reset();
    run_instr(7'b0000000, 3'b000, 7'd0, 0, 0, 0);
    checks++; if (c_rw !== 0 || c_mw !== 0 || c_ret !== 0) begin
      errors++; $display("FAIL illegal_strobes got rw=%0d mw=%0d ret=%0d want 0 0 0", c_rw, c_mw, c_ret);
    end
    repeat (3) begin
      #1;
      checks++; if (trap !== 1'b1 || MemRead !== 1'b0) begin
        errors++; $display("FAIL trap_hold got trap=%0b memread=%0b want 1 0", trap, MemRead);
      end
      @(negedge clk);
    end
    #2;
    reset_n = 1'b0; mem_ready = 1'b0;
    #1;
    checks++; if (outs1 !== 25'd0) begin errors++; $display("FAIL trap_async_reset got %h want 0", outs1); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (trap !== 1'b0 || MemRead !== 1'b1) begin
      errors++; $display("FAIL trap_exit got trap=%0b memread=%0b want 0 1", trap, MemRead);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_memwrite();
    logic seen;
    do_reset();
    op = OP_STORE; funct3 = 3'b010; funct7 = 7'd0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (MemWrite) begin seen = 1'b1; mem_ready = 1'b0; end
      else begin mem_ready = 1'b1; @(negedge clk); end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL store_reach got %0b want 1", seen); end
    @(posedge clk);
    #2;
    checks++; if (MemWrite !== 1'b1 || retire !== 1'b0) begin
      errors++; $display("FAIL store_wait got mw=%0b ret=%0b want 1 0", MemWrite, retire);
    end
    reset_n = 1'b0;
    #1;
    checks++; if (MemWrite !== 1'b0 || retire !== 1'b0 || outs1 !== 25'd0) begin
      errors++; $display("FAIL store_abort got mw=%0b ret=%0b outs=%h want 0 0 0", MemWrite, retire, outs1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (MemWrite !== 1'b0 || MemRead !== 1'b1) begin
      errors++; $display("FAIL store_restart got mw=%0b mr=%0b want 0 1", MemWrite, MemRead);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [6:0] o, f7;
    logic [2:0] f3;
    int k, fw, mw, mk, ecyc;
    logic is_mul, tk;
    logic [2:0] brf [0:5];
    brf[0] = 3'd0; brf[1] = 3'd1; brf[2] = 3'd4; brf[3] = 3'd5; brf[4] = 3'd6; brf[5] = 3'd7;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'($urandom_range(0, 127));
      case (k)
        0: o = OP_LOAD;
        1: o = OP_STORE;
        2: begin o = OP_R; f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000; end
        3: o = OP_I;
        4: begin o = OP_BR; f3 = brf[$urandom_range(0, 5)]; end
        5: o = OP_JAL;
        6: o = OP_JALR;
        7: o = OP_LUI;
        8: o = OP_AUIPC;
        default: begin o = OP_R; f7 = F7_M; end
      endcase
      eq = 1'($urandom_range(0, 1)); lt = 1'($urandom_range(0, 1)); ltu = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 2); mw = $urandom_range(0, 3); mk = $urandom_range(0, 4);
      is_mul = (o == OP_R) && (f7 == F7_M);
      tk = (o == OP_BR) && model_taken(f3, eq, lt, ltu);
      ecyc = model_cycles(o, f7, fw, mw, mk);
      run_instr(o, f3, f7, fw, mw, mk);
      checks++; if (c_cyc !== ecyc) begin errors++; $display("FAIL rand_cycles n=%0d op=%b got %0d want %0d", n, o, c_cyc, ecyc); end
      checks++; if (c_ret !== 1 || c_ir !== 1 || c_irbad !== 0) begin
        errors++; $display("FAIL rand_retire_ir n=%0d got ret=%0d ir=%0d irbad=%0d want 1 1 0", n, c_ret, c_ir, c_irbad);
      end
      checks++; if (c_rw !== ((o == OP_STORE || o == OP_BR) ? 0 : 1)) begin
        errors++; $display("FAIL rand_regwrite n=%0d op=%b got %0d", n, o, c_rw);
      end
      checks++; if (c_mw !== ((o == OP_STORE) ? 1 + mw : 0) || c_mr !== (1 + fw + ((o == OP_LOAD) ? 1 + mw : 0))) begin
        errors++; $display("FAIL rand_mem n=%0d op=%b got mw=%0d mr=%0d", n, o, c_mw, c_mr);
      end
      checks++; if (c_pc !== (1 + (tk ? 1 : 0) + ((o == OP_JAL || o == OP_JALR) ? 1 : 0))) begin
        errors++; $display("FAIL rand_pcwrite n=%0d op=%b f3=%b got %0d taken=%0b", n, o, f3, c_pc, tk);
      end
      checks++; if (c_ms !== (is_mul ? 1 : 0)) begin errors++; $display("FAIL rand_mulstart n=%0d got %0d want %0d", n, c_ms, is_mul); end
      if (c_rw == 1) begin
        checks++; if (rs_rw !== ((o == OP_LOAD) ? 2'b01 : (is_mul ? 2'b11 : 2'b00))) begin
          errors++; $display("FAIL rand_resultsrc n=%0d op=%b got %b", n, o, rs_rw);
        end
      end
      if ((o == OP_R && !is_mul) || o == OP_I) begin
        checks++; if (alu_at[2 + fw] !== model_alu(o == OP_R, f3, f7)) begin
          errors++; $display("FAIL rand_aluctl n=%0d op=%b f3=%b f7=%b got %b want %b", n, o, f3, f7,
                             alu_at[2 + fw], model_alu(o == OP_R, f3, f7));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_load_wait();
    test_bne();
    test_muldiv();
    test_illegal();
    test_reset_memwrite();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_mc_controller.md
# rv32_mc_controller

Multicycle successor to the single-cycle RV32I control unit: a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles and drives a shared-ALU, single-memory datapath. It adds a variable-latency memory handshake, optional RV32M dispatch to an iterative mul/div unit, and illegal-opcode halting. It sits beside the multicycle datapath; instruction fields come from the datapath's instruction register.

## Interface
- MEM_WAIT, 1: 1 = wait on `mem_ready`; 0 = `mem_ready` treated as 1.
- MULDIV_EN, 0: 1 = decode RV32M (op 0110011, funct7 0000001) to the MULDIV path; 0 = such encodings trap.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode from IR.
- funct3  in  3  funct3 from IR.
- funct7  in  7  funct7 from IR.
- eq, lt, ltu  in  1 each  ALU compare flags for rs1 vs rs2, valid in BRANCH.
- mem_ready  in  1  memory access completes this cycle.
- mul_done  in  1  mul/div result valid.
- PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc  out  1 each  datapath strobes and selects.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 load data, 10 ALUResult, 11 mul/div result.
- ImmSrc  out  3  I 000, S 001, B 010, U 011, J 100.
- ALUControl  out  4  ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
- LdStrSrc  out  3  equals funct3.
- mul_start  out  1  one-cycle start pulse to mul/div unit.
- retire  out  1  one-cycle pulse in each instruction's final state.
- trap  out  1  high while halted on illegal instruction.

## Operation
- FETCH: MemRead=1, AdrSrc=0, A=PC, B=4, ADD, ResultSrc=10. IRWrite=PCWrite=mem_ready. Leave to DECODE on mem_ready; otherwise hold.
- DECODE: A=OldPC, B=imm, ADD. ImmSrc=J if op=1101111, else B. Next state by op: 0000011/0100011 MEMADR; 0110011 EXECUTER or MULDIV; 0010011 EXECUTEI; 1100011 BRANCH; 1101111 JAL; 1100111 JALR; 0110111/0010111 UTYPE; any other op TRAP.
- MEMADR: A=rs1, B=imm, ADD, ImmSrc I for loads and S for stores. Next state MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: AdrSrc=1, MemRead=1. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire. Next state FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until mem_ready. Retire on that cycle, then FETCH.
- EXECUTER: A=rs1, B=rs2. EXECUTEI: A=rs1, B=imm(I). Both go to ALUWB.
  - funct3 map: 000 ADD (SUB when R-type and funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7[5], 110 OR, 111 AND.
  - I-type 000 never yields SUB.
- ALUWB: ResultSrc=00, RegWrite=1, retire. Next state FETCH.
- BRANCH: A=rs1, B=rs2, SUB, ResultSrc=00. PCWrite = taken, retire. Next state FETCH.
  - taken: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010/011 go to TRAP instead.
- JALR: A=rs1, B=imm(I), ADD. Next state JAL.
- JAL: A=OldPC, B=4, ADD, ResultSrc=00, PCWrite=1. Next state ALUWB, which writes PC+4 to rd.
- UTYPE: A=zero for LUI or OldPC for AUIPC, B=imm(U), ADD. Next state ALUWB.
- MULDIV (MULDIV_EN=1 only): mul_start=1 on the entry cycle only. Hold until mul_done, then MULWB.
- MULWB: ResultSrc=11, RegWrite=1, retire. Next state FETCH.
- TRAP: trap=1, all write strobes 0. Absorbing state; only reset exits.
- Any output not listed for a state is 0.

## Timing
- Asynchronous reset: state → FETCH immediately. While reset_n=0, every output is 0, including MemRead.
- First FETCH outputs appear in the first cycle after reset_n rises.
- Reset asserted mid-instruction aborts it; no partial RegWrite or MemWrite is issued after assertion.
- Outputs are combinational from the current state plus IR fields and flags. The state register is the only flop (plus the mul_start entry flag).
- Latency with mem_ready always 1:
  - load 5 cycles; store 4; R/I ALU 4; branch 3; JAL 4; JALR 5; LUI/AUIPC 4.
  - MULDIV is 4 + cycles until mul_done.
- Each wait cycle on mem_ready adds exactly one cycle. IRWrite/PCWrite never assert before mem_ready.
- mul_done already high on MULDIV entry: mul_start still pulses; exit to MULWB the next cycle.

## Test plan
- ADD then SUB (0110011, funct3 000, funct7 0000000/0100000), mem_ready=1 → states FETCH, DECODE, EXECUTER, ALUWB; ALUControl 0000 then 0001; one retire per instruction.
- Load with mem_ready low 3 cycles in MEMREAD → MemRead, AdrSrc held 3 extra cycles; MEMWB RegWrite=1, ResultSrc=01; 8 cycles total.
- BNE (funct3 001) with eq=1, then eq=0 → PCWrite 0 then 1 in BRANCH; 3 cycles each.
- MULDIV_EN=1, funct7 0000001, mul_done after 5 cycles → single mul_start pulse, MULWB ResultSrc=11. Same instruction with MULDIV_EN=0 → trap=1, held until reset.
- Op 0000000 → TRAP; then reset_n low mid-TRAP → all outputs 0 asynchronously; FETCH after release.
- reset_n asserted during MEMWRITE wait → MemWrite drops without waiting for a clock edge; no retire.
